// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/response bundle for the iterative shifter.
//   Request : in_valid, in_ready, in_data, in_mode, in_amt
//   Response: out_valid, out_ready, out_data, out_carry, out_zero, out_err
//   Status  : busy
// slave modport is the shifter side; master modport is the requester/consumer side.
interface iter_shifter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_mode, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err, busy
    );

    modport master (
        output in_valid, in_data, in_mode, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err, busy
    );
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift/rotate unit, one bit position per clock.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : iter_shifter_if.slave (request handshake, result handshake, busy)
// Modes: 000 PASS, 001 LSL, 010 LSR, 011 ASR, 100 ROR, 101 ROL, 11x reserved.
module iter_shifter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    iter_shifter_if.slave bus
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {
        M_PASS = 3'b000, M_LSL = 3'b001, M_LSR = 3'b010,
        M_ASR  = 3'b011, M_ROR = 3'b100, M_ROL = 3'b101
    } mode_t;

    state_t           state;
    mode_t            mode_q;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic             carry_q;
    logic             err_q;

    logic [WIDTH-1:0] od_q;
    logic             ov_q, oc_q, oz_q, oe_q;

    // accept-time decode
    mode_t            ld_mode;
    logic [AMT_W-1:0] ld_n;
    logic             ld_carry;
    logic             ld_err;
    logic [AMT_W-1:0] sat_amt;
    logic [SH_W-1:0]  amt_mod;

    // single-bit step
    logic [WIDTH-1:0] step_data;
    logic             step_c;

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == SHIFT);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_carry = oc_q;
    assign bus.out_zero  = oz_q;
    assign bus.out_err   = oe_q;

    always_comb begin
        amt_mod  = bus.in_amt[SH_W-1:0];
        // WIDTH+1 steps are enough to saturate any linear shift
        sat_amt  = (bus.in_amt > AMT_W'(WIDTH + 1)) ? AMT_W'(WIDTH + 1) : bus.in_amt;
        ld_mode  = M_PASS;
        ld_n     = '0;
        ld_carry = 1'b0;
        ld_err   = 1'b0;
        case (bus.in_mode)
            M_PASS: ld_mode = M_PASS;
            M_LSL: begin ld_mode = M_LSL; ld_n = sat_amt; end
            M_LSR: begin ld_mode = M_LSR; ld_n = sat_amt; end
            M_ASR: begin ld_mode = M_ASR; ld_n = sat_amt; end
            M_ROR: begin
                ld_mode = M_ROR;
                ld_n    = {{(AMT_W - SH_W){1'b0}}, amt_mod};
                // whole-turn rotate: no steps, carry is the last bit that
                // would have come around
                if (amt_mod == '0 && bus.in_amt != '0)
                    ld_carry = bus.in_data[WIDTH-1];
            end
            M_ROL: begin
                ld_mode = M_ROL;
                ld_n    = {{(AMT_W - SH_W){1'b0}}, amt_mod};
                if (amt_mod == '0 && bus.in_amt != '0)
                    ld_carry = bus.in_data[0];
            end
            default: ld_err = 1'b1;
        endcase
    end

    always_comb begin
        step_data = work;
        step_c    = carry_q;
        case (mode_q)
            M_LSL: begin step_data = {work[WIDTH-2:0], 1'b0};         step_c = work[WIDTH-1]; end
            M_LSR: begin step_data = {1'b0, work[WIDTH-1:1]};         step_c = work[0];       end
            M_ASR: begin step_data = {work[WIDTH-1], work[WIDTH-1:1]}; step_c = work[0];      end
            M_ROR: begin step_data = {work[0], work[WIDTH-1:1]};      step_c = work[0];       end
            M_ROL: begin step_data = {work[WIDTH-2:0], work[WIDTH-1]}; step_c = work[WIDTH-1]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mode_q  <= M_PASS;
            work    <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            oc_q    <= 1'b0;
            oz_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work    <= bus.in_data;
                        mode_q  <= ld_mode;
                        cnt     <= ld_n;
                        carry_q <= ld_carry;
                        err_q   <= ld_err;
                        state   <= (ld_n != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    work    <= step_data;
                    carry_q <= step_c;
                    cnt     <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    // first DONE cycle registers the result and flags;
                    // they are held until consumed, then cleared
                    if (!ov_q) begin
                        od_q <= work;
                        oc_q <= carry_q;
                        oz_q <= (work == '0);
                        oe_q <= err_q;
                        ov_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        od_q  <= '0;
                        oc_q  <= 1'b0;
                        oz_q  <= 1'b0;
                        oe_q  <= 1'b0;
                        ov_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    iter_shifter_if #(.WIDTH(16), .AMT_W(5)) bus ();

    iter_shifter #(.WIDTH(16), .AMT_W(5)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for in_ready (bounded), present one request, leave just after the accept edge.
    task automatic send(input logic [2:0] mode, input logic [15:0] data, input logic [4:0] amt);
        int n;
        n = 0;
        while (!bus.in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL send_ready: in_ready=%0b want 1", bus.in_ready);
        end
        bus.in_mode  = mode;
        bus.in_data  = data;
        bus.in_amt   = amt;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_ctrl: rdy/vld/busy=%b want 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== 19'h0) begin
            bad++;
            $display("FAIL reset_out: data=%h c=%b z=%b e=%b want 0", bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lsl();
        int lat;
        send(3'b001, 16'h8001, 5'd1);
        wait_valid(lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL lsl_lat: got %0d want 2", lat); end
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {16'h0002, 3'b100}) begin
            bad++;
            $display("FAIL lsl_8001_1: data=%h c=%b z=%b e=%b want 0002 1 0 0", bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
        end
        retire();
        // amt > WIDTH saturates to zero with carry 0
        send(3'b001, 16'hFFFF, 5'd17);
        wait_valid(lat);
        total++;
        if (lat !== 18) begin bad++; $display("FAIL lsl_sat_lat: got %0d want 18", lat); end
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_zero} !== {16'h0000, 2'b01}) begin
            bad++;
            $display("FAIL lsl_sat: data=%h c=%b z=%b want 0000 0 1", bus.out_data, bus.out_carry, bus.out_zero);
        end
        retire();
    endtask

    task automatic test_lsr();
        int lat;
        send(3'b010, 16'h0001, 5'd1);
        wait_valid(lat);
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_zero} !== {16'h0000, 2'b11}) begin
            bad++;
            $display("FAIL lsr_0001_1: data=%h c=%b z=%b want 0000 1 1", bus.out_data, bus.out_carry, bus.out_zero);
        end
        retire();
        // amt == WIDTH: last bit out is the original MSB
        send(3'b010, 16'h8001, 5'd16);
        wait_valid(lat);
        total++;
        if (lat !== 17) begin bad++; $display("FAIL lsr16_lat: got %0d want 17", lat); end
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_zero} !== {16'h0000, 2'b11}) begin
            bad++;
            $display("FAIL lsr_8001_16: data=%h c=%b z=%b want 0000 1 1", bus.out_data, bus.out_carry, bus.out_zero);
        end
        retire();
    endtask

    task automatic test_asr();
        int lat;
        send(3'b011, 16'h8000, 5'd4);
        wait_valid(lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL asr4_lat: got %0d want 5", lat); end
        total++;
        if ({bus.out_data, bus.out_carry} !== {16'hF800, 1'b0}) begin
            bad++;
            $display("FAIL asr_8000_4: data=%h c=%b want f800 0", bus.out_data, bus.out_carry);
        end
        retire();
        send(3'b011, 16'h8000, 5'd20);
        wait_valid(lat);
        total++;
        if (lat !== 18) begin bad++; $display("FAIL asr20_lat: got %0d want 18", lat); end
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_zero} !== {16'hFFFF, 2'b10}) begin
            bad++;
            $display("FAIL asr_8000_20: data=%h c=%b z=%b want ffff 1 0", bus.out_data, bus.out_carry, bus.out_zero);
        end
        retire();
    endtask

    task automatic test_rotate();
        int lat;
        send(3'b100, 16'h0001, 5'd1);
        wait_valid(lat);
        total++;
        if ({bus.out_data, bus.out_carry} !== {16'h8000, 1'b1}) begin
            bad++;
            $display("FAIL ror_0001_1: data=%h c=%b want 8000 1", bus.out_data, bus.out_carry);
        end
        retire();
        send(3'b100, 16'h1234, 5'd16);
        wait_valid(lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL ror16_lat: got %0d want 1", lat); end
        total++;
        if ({bus.out_data, bus.out_carry} !== {16'h1234, 1'b0}) begin
            bad++;
            $display("FAIL ror_1234_16: data=%h c=%b want 1234 0", bus.out_data, bus.out_carry);
        end
        retire();
        // whole-turn ROL carries out in_data[0]
        send(3'b101, 16'h8001, 5'd16);
        wait_valid(lat);
        total++;
        if ({bus.out_data, bus.out_carry} !== {16'h8001, 1'b1}) begin
            bad++;
            $display("FAIL rol_8001_16: data=%h c=%b want 8001 1", bus.out_data, bus.out_carry);
        end
        retire();
        send(3'b101, 16'h8000, 5'd1);
        wait_valid(lat);
        total++;
        if ({bus.out_data, bus.out_carry} !== {16'h0001, 1'b1}) begin
            bad++;
            $display("FAIL rol_8000_1: data=%h c=%b want 0001 1", bus.out_data, bus.out_carry);
        end
        retire();
        // 19 mod 16 = 3 steps
        send(3'b100, 16'h000C, 5'd19);
        wait_valid(lat);
        total++;
        if ({bus.out_data, bus.out_carry} !== {16'h8001, 1'b1}) begin
            bad++;
            $display("FAIL ror_000c_19: data=%h c=%b want 8001 1", bus.out_data, bus.out_carry);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(3'b001, 16'h0003, 5'd2);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_mode  = 3'b000;
            bus.in_data  = 16'hDEAD;
            @(posedge clk); #1;
            total++;
            if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_carry, bus.out_zero} !== {2'b10, 16'h000C, 2'b00}) begin
                bad++;
                $display("FAIL hold_%0d: vld=%b rdy=%b data=%h c=%b z=%b want 1 0 000c 0 0", i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_carry, bus.out_zero);
            end
        end
        // consume while a new request is already waiting
        bus.in_valid  = 1'b1;
        bus.in_mode   = 3'b000;
        bus.in_data   = 16'h1111;
        bus.in_amt    = 5'd0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL idle_after_pop: rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL first_idle_accept: rdy=%b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h1111}) begin
            bad++;
            $display("FAIL b2b_pass: vld=%b data=%h want 1 1111", bus.out_valid, bus.out_data);
        end
        retire();
    endtask

    task automatic test_reset_mid();
        int lat;
        send(3'b001, 16'h00FF, 5'd8);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: busy=%b want 1", bus.busy);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL mid_reset: rdy/vld/busy=%b want 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(3'b000, 16'hABCD, 5'd3);
        wait_valid(lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL pass_lat: got %0d want 1", lat); end
        total++;
        if ({bus.out_data, bus.out_carry, bus.out_err} !== {16'hABCD, 2'b00}) begin
            bad++;
            $display("FAIL pass_abcd: data=%h c=%b e=%b want abcd 0 0", bus.out_data, bus.out_carry, bus.out_err);
        end
        retire();
    endtask

    task automatic test_reserved();
        int lat;
        send(3'b111, 16'h5A5A, 5'd4);
        wait_valid(lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL rsv_lat: got %0d want 1", lat); end
        total++;
        if ({bus.out_data, bus.out_err, bus.out_carry, bus.out_zero} !== {16'h5A5A, 3'b100}) begin
            bad++;
            $display("FAIL rsv_5a5a: data=%h e=%b c=%b z=%b want 5a5a 1 0 0", bus.out_data, bus.out_err, bus.out_carry, bus.out_zero);
        end
        retire();
        send(3'b001, 16'h0001, 5'd3);
        wait_valid(lat);
        total++;
        if ({bus.out_data, bus.out_err} !== {16'h0008, 1'b0}) begin
            bad++;
            $display("FAIL lsl_after_rsv: data=%h e=%b want 0008 0", bus.out_data, bus.out_err);
        end
        retire();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_lsl();
        test_lsr();
        test_asr();
        test_rotate();
        test_back_to_back();
        test_reset_mid();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
